gpio_pad_ctrl: RTL and testbench

Register-mapped controller for a bank of `GenericDigitalGPIOCell` pads. It sits directly upstream of the pad ring: it drives each cell's `o`/`oe`/`ie` and consumes each cell's `i`. The `i` return is synchronized, optionally debounced, and edge-detected into a sticky interrupt-pending register. Core masters reach it through a single-beat valid/ready register port.

---
 rtl/gpio_ctrl_pkg.sv | 17 +
 rtl/gpio_pin_filter.sv | 108 ++++++++++
 rtl/gpio_pad_ctrl.sv | 144 ++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared definitions for the GPIO pad controller.
//   gpio_addr_t       - 3-bit register index type
//   ADDR_OUT..RSVD    - register map indices
package gpio_ctrl_pkg;

  typedef logic [2:0] gpio_addr_t;

  localparam gpio_addr_t ADDR_OUT      = 3'd0;
  localparam gpio_addr_t ADDR_OE       = 3'd1;
  localparam gpio_addr_t ADDR_IE       = 3'd2;
  localparam gpio_addr_t ADDR_IN       = 3'd3;
  localparam gpio_addr_t ADDR_RISE_EN  = 3'd4;
  localparam gpio_addr_t ADDR_FALL_EN  = 3'd5;
  localparam gpio_addr_t ADDR_IRQ_PEND = 3'd6;
  localparam gpio_addr_t ADDR_RSVD     = 3'd7;

endpackage

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: per-pin input conditioning.
//   Synchronizes the asynchronous pad input, optionally debounces it
//   (GPIO_CTRL_DEBOUNCE_EN), and detects qualified rising/falling edges.
// Ports:
//   clock, reset      - clock, async active-high reset
//   pad_i             - raw cell input (asynchronous)
//   ie                - input-enable currently driven to the cell
//   rise_en, fall_en  - edge enables for this pin
//   f                 - filtered input value
//   rise_pulse        - one-cycle pulse on a qualified rising edge of f
//   fall_pulse        - one-cycle pulse on a qualified falling edge of f
module gpio_pin_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_i,
  input  logic ie,
  input  logic rise_en,
  input  logic fall_en,
  output logic f,
  output logic rise_pulse,
  output logic fall_pulse
);

`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int DB_EN = 1;
`else
  localparam int DB_EN = 0;
`endif
  // The IE copy travels through as many flops as the data does, so it lines
  // up with the F sample that the cell's ie setting actually affected.
  localparam int LAT = SYNC_STAGES + ((DB_EN != 0) ? DEBOUNCE_CYCLES : 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [LAT-1:0]         ie_pipe_q, ie_pipe_d;
  logic                   ie_prev_q, ie_prev_d;
  logic                   f_prev_q, f_prev_d;
  logic                   sync_out, ie_ok;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pad_i};
    ie_pipe_d = {ie_pipe_q[LAT-2:0], ie};
    ie_prev_d = ie_pipe_q[LAT-1];
    f_prev_d  = f;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      ie_pipe_q <= '0;
      ie_prev_q <= 1'b0;
      f_prev_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      ie_pipe_q <= ie_pipe_d;
      ie_prev_q <= ie_prev_d;
      f_prev_q  <= f_prev_d;
    end
  end

`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          f_q, f_d;

  // F flips on the edge that would bring the count to DEBOUNCE_CYCLES, so the
  // total input latency is exactly SYNC_STAGES + DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    f_d   = f_q;
    if (sync_out == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      f_d   = sync_out;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      f_q   <= f_d;
    end
  end

  assign f = f_q;
`else
  assign f = sync_out;
`endif

  // Both F samples must have been taken with the cell enabled; otherwise the
  // cell's forced 0 during an IE change would look like a real edge.
  assign ie_ok      = ie_pipe_q[LAT-1] & ie_prev_q;
  assign rise_pulse =  f & ~f_prev_q & rise_en & ie_ok;
  assign fall_pulse = ~f &  f_prev_q & fall_en & ie_ok;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: register-mapped controller for a bank of generic GPIO cells.
//   Drives pad o/oe/ie from registers, conditions pad i through a per-pin
//   filter and collects edges into a sticky W1C IRQ_PEND register.
//   Optional debounce on the input path: define GPIO_CTRL_DEBOUNCE_EN.
// Ports:
//   clock, reset                  - clock, async active-high reset
//   req_valid/ready/write/addr/wdata - single-beat register request
//   resp_valid/ready/rdata        - register response (rdata 0 for writes)
//   pad_i                         - from cell i (asynchronous)
//   pad_o, pad_oe, pad_ie         - to cell o/oe/ie, straight from flops
//   irq                           - OR of IRQ_PEND
module gpio_pad_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NPINS           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  gpio_addr_t       req_addr,
  input  logic [NPINS-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [NPINS-1:0] resp_rdata,
  input  logic [NPINS-1:0] pad_i,
  output logic [NPINS-1:0] pad_o,
  output logic [NPINS-1:0] pad_oe,
  output logic [NPINS-1:0] pad_ie,
  output logic             irq
);

  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] oe_q, oe_d;
  logic [NPINS-1:0] ie_q, ie_d;
  logic [NPINS-1:0] rise_en_q, rise_en_d;
  logic [NPINS-1:0] fall_en_q, fall_en_d;
  logic [NPINS-1:0] pend_q, pend_d;
  logic [NPINS-1:0] rdata_q, rdata_d;
  logic             resp_valid_q, resp_valid_d;

  logic [NPINS-1:0] in_f, rise_p, fall_p, rd_mux;
  logic             accept;

  for (genvar k = 0; k < NPINS; k++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clock     (clock),
      .reset     (reset),
      .pad_i     (pad_i[k]),
      .ie        (ie_q[k]),
      .rise_en   (rise_en_q[k]),
      .fall_en   (fall_en_q[k]),
      .f         (in_f[k]),
      .rise_pulse(rise_p[k]),
      .fall_pulse(fall_p[k])
    );
  end

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  // Read data reflects register contents before this cycle's updates.
  always_comb begin
    rd_mux = '0;
    case (req_addr)
      ADDR_OUT:      rd_mux = out_q;
      ADDR_OE:       rd_mux = oe_q;
      ADDR_IE:       rd_mux = ie_q;
      ADDR_IN:       rd_mux = in_f;
      ADDR_RISE_EN:  rd_mux = rise_en_q;
      ADDR_FALL_EN:  rd_mux = fall_en_q;
      ADDR_IRQ_PEND: rd_mux = pend_q;
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    oe_d         = oe_q;
    ie_d         = ie_q;
    rise_en_d    = rise_en_q;
    fall_en_d    = fall_en_q;
    pend_d       = pend_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;

    if (accept && req_write) begin
      case (req_addr)
        ADDR_OUT:      out_d     = req_wdata;
        ADDR_OE:       oe_d      = req_wdata;
        ADDR_IE:       ie_d      = req_wdata;
        ADDR_RISE_EN:  rise_en_d = req_wdata;
        ADDR_FALL_EN:  fall_en_d = req_wdata;
        ADDR_IRQ_PEND: pend_d    = pend_q & ~req_wdata;
        default:       ;
      endcase
    end
    // Applied after the clear so a same-cycle edge keeps its bit set.
    pend_d = pend_d | rise_p | fall_p;

    if (accept) begin
      resp_valid_d = 1'b1;
      rdata_d      = req_write ? '0 : rd_mux;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      oe_q         <= '0;
      ie_q         <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      pend_q       <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      oe_q         <= oe_d;
      ie_q         <= ie_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      pend_q       <= pend_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign pad_o      = out_q;
  assign pad_oe     = oe_q;
  assign pad_ie     = ie_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign irq        = |pend_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl. Responses are checked against a queue of
// expected read data; pad/irq behaviour is checked directly. The pad cell is
// modelled as i = raw & ie (disabled input reads 0).
module tb_gpio_pad_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int NP = 8;
`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int L = 6;
`else
  localparam int L = 2;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  gpio_addr_t    req_addr;
  logic [NP-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [NP-1:0] resp_rdata;
  logic [NP-1:0] pad_i, pad_o, pad_oe, pad_ie, pad_raw;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;
  logic [NP-1:0] exp_q[$];

  assign pad_i = pad_raw & pad_ie;

  always #5 clock = ~clock;

  gpio_pad_ctrl #(.NPINS(NP), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe), .pad_ie(pad_ie), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response side of the scoreboard.
  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL resp_unexpected: observed rdata %0h expected no response", resp_rdata);
      end else begin
        chk("resp_rdata", 32'(resp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 of the accept edge.
  task automatic bus(input logic w, input gpio_addr_t a, input logic [NP-1:0] d,
                     input logic [NP-1:0] e);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    exp_q.push_back(e);
    @(negedge clock);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL req_timeout: observed req_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = ADDR_OUT;
    req_wdata = '0; resp_ready = 1'b1; pad_raw = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pad_o", 32'(pad_o), 0);
    chk("rst_pad_oe", 32'(pad_oe), 0);
    chk("rst_pad_ie", 32'(pad_ie), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    @(posedge clock); #1;
    reset = 1'b0;
    tick(1);
    for (int a = 0; a < 8; a++) bus(1'b0, gpio_addr_t'(a), '0, '0);

    // Outputs
    bus(1'b1, ADDR_OE, 8'hFF, '0);
    chk("pad_oe", 32'(pad_oe), 32'hFF);
    chk("pad_o_pre", 32'(pad_o), 0);
    bus(1'b1, ADDR_OUT, 8'hA5, '0);
    chk("pad_o", 32'(pad_o), 32'hA5);
    bus(1'b0, ADDR_OUT, '0, 8'hA5);
    bus(1'b1, ADDR_IN, 8'hFF, '0);
    bus(1'b0, ADDR_RSVD, '0, '0);

    // Rising edge on pin 0
    bus(1'b1, ADDR_IE, 8'h01, '0);
    chk("pad_ie", 32'(pad_ie), 32'h01);
    bus(1'b1, ADDR_RISE_EN, 8'h01, '0);
    tick(2);
    pad_raw[0] = 1'b1;
    repeat (L) @(posedge clock);
    @(negedge clock);
    chk("irq_early", 32'(irq), 0);
    @(negedge clock);
    chk("irq_rise0", 32'(irq), 1);
    @(posedge clock); #1;
    bus(1'b0, ADDR_IN, '0, 8'h01);
    bus(1'b0, ADDR_IRQ_PEND, '0, 8'h01);
    bus(1'b1, ADDR_IRQ_PEND, 8'h01, '0);
    chk("irq_clr", 32'(irq), 0);

`ifdef GPIO_CTRL_DEBOUNCE_EN
    // Debounce: 3-cycle pulse rejected, 4-cycle stable level accepted
    bus(1'b1, ADDR_IE, 8'h02, '0);
    bus(1'b1, ADDR_RISE_EN, 8'h02, '0);
    tick(L + 2);
    pad_raw[1] = 1'b1;
    tick(3);
    pad_raw[1] = 1'b0;
    tick(L + 4);
    chk("db_short_irq", 32'(irq), 0);
    bus(1'b0, ADDR_IN, '0, 8'h00);
    pad_raw[1] = 1'b1;
    tick(L + 4);
    bus(1'b0, ADDR_IN, '0, 8'h02);
    chk("db_long_irq", 32'(irq), 1);
`endif
    bus(1'b1, ADDR_IRQ_PEND, 8'hFF, '0);
    chk("irq_clr_all", 32'(irq), 0);

    // IE toggle on a held-high pin must not raise edges
    bus(1'b1, ADDR_FALL_EN, 8'h04, '0);
    bus(1'b1, ADDR_RISE_EN, 8'h04, '0);
    pad_raw[2] = 1'b1;
    bus(1'b1, ADDR_IE, 8'h04, '0);
    tick(L + 4);
    bus(1'b1, ADDR_IE, 8'h00, '0);
    tick(L + 4);
    bus(1'b1, ADDR_IE, 8'h04, '0);
    tick(L + 4);
    bus(1'b0, ADDR_IRQ_PEND, '0, 8'h00);
    chk("ie_toggle_irq", 32'(irq), 0);
    bus(1'b0, ADDR_IN, '0, 8'h04);

    // W1C collision: clear accepted on the edge that sets the bit
    pad_raw[0] = 1'b0;
    bus(1'b1, ADDR_RISE_EN, 8'h01, '0);
    bus(1'b1, ADDR_IE, 8'h05, '0);
    tick(L + 4);
    pad_raw[0] = 1'b1;
    tick(L);
    bus(1'b1, ADDR_IRQ_PEND, 8'h01, '0);
    bus(1'b0, ADDR_IRQ_PEND, '0, 8'h01);
    chk("collide_irq", 32'(irq), 1);
    bus(1'b1, ADDR_IRQ_PEND, 8'h01, '0);
    chk("collide_clr", 32'(irq), 0);
    tick(1);

    // Backpressure: response held, next request stalled
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_OUT;
    exp_q.push_back(8'hA5);
    tick(1);
    req_addr = ADDR_OE;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_resp_valid", 32'(resp_valid), 1);
      chk("bp_resp_rdata", 32'(resp_rdata), 32'hA5);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    tick(2);

    // Reset with a response outstanding discards it
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_OUT;
    tick(1);
    req_valid = 1'b0;
    chk("mid_resp_valid", 32'(resp_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_pad_o", 32'(pad_o), 0);
    tick(2);
    reset = 1'b0;
    resp_ready = 1'b1;
    tick(4);
    chk("post_rst_resp_valid", 32'(resp_valid), 0);
    chk("post_rst_rdata", 32'(resp_rdata), 0);
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
